uart_rx: RTL

Asynchronous serial receiver, 8N1, LSB first; the receive-side counterpart of the board's UART transmit path. It samples the RS232/USB input line, validates the start and stop bits, and presents each byte on a valid/read handshake. Downstream logic (command parser, loopback, TRNG control) consumes the bytes. Bit period is runtime-programmable with the same encoding as the transmitter, so a single divider value configures both directions.

---
 rtl/uart_pkg.sv | 15 +
 rtl/sync2.sv | 27 ++
 rtl/uart_rx.sv | 132 +++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions for the receive and transmit paths.
package uart_pkg;

    localparam int UART_DATA_BITS = 8;
    localparam int UART_MIN_CPB   = 3;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } uart_state_t;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for asynchronous inputs, with a selectable reset value.
module sync2 #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] sync_p0;
    logic [WIDTH-1:0] sync_p1;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync_p0 <= RESET_VAL;
            sync_p1 <= RESET_VAL;
        end else begin
            sync_p0 <= d;
            sync_p1 <= sync_p0;
        end
    end

    assign q = sync_p1;

endmodule

// File: rtl/uart_rx.sv
// 8N1 serial receiver, LSB first, with runtime bit period and valid/read handshake.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CPB_WIDTH = 32
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    input  logic [CPB_WIDTH-1:0] i_cycles_per_bit,
    input  logic                 i_sin,
    input  logic                 i_read,
    output logic [7:0]           o_dat,
    output logic                 o_valid,
    output logic                 o_frame_err,
    output logic                 o_overrun,
    output logic                 o_busy
);

    logic s;

    sync2 #(
        .WIDTH    (1),
        .RESET_VAL(1'b1)
    ) u_sync (
        .clk    (i_clk),
        .reset_n(i_reset_n),
        .d      (i_sin),
        .q      (s)
    );

    uart_state_t               state_q, state_d;
    logic [CPB_WIDTH-1:0]      cnt_q, cnt_d;
    logic [2:0]                idx_q, idx_d;
    logic [UART_DATA_BITS-1:0] sh_q, sh_d;
    logic                      deliver;
    logic                      frame_err;
    logic                      half_hit;
    logic                      full_hit;

    assign half_hit = (cnt_q == (i_cycles_per_bit >> 1));
    assign full_hit = (cnt_q == i_cycles_per_bit);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + CPB_WIDTH'(1);
        idx_d     = idx_q;
        sh_d      = sh_q;
        deliver   = 1'b0;
        frame_err = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!s) state_d = START;
            end
            START: begin
                // Mid-start sample rejects glitches shorter than half a bit.
                if (half_hit) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (full_hit) begin
                    cnt_d = '0;
                    sh_d  = {s, sh_q[UART_DATA_BITS-1:1]};
                    if (idx_q == 3'(UART_DATA_BITS - 1)) state_d = STOP;
                    else idx_d = idx_q + 3'd1;
                end
            end
            STOP: begin
                if (full_hit) begin
                    cnt_d = '0;
                    if (s) begin
                        deliver = 1'b1;
                        state_d = IDLE;
                    end else begin
                        frame_err = 1'b1;
                        state_d   = BREAK;
                    end
                end
            end
            BREAK: begin
                // Wait out a held-low line so it cannot look like a new start bit.
                cnt_d = '0;
                if (s) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
        end
    end

    always_ff @(posedge i_clk) begin
        sh_q <= sh_d;
    end

    // Output stage: a delivery with a simultaneous read replaces the unread byte.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            o_dat       <= 8'h00;
            o_valid     <= 1'b0;
            o_frame_err <= 1'b0;
            o_overrun   <= 1'b0;
        end else begin
            o_frame_err <= frame_err;
            if (deliver) begin
                if (!o_valid || i_read) begin
                    o_dat   <= sh_q;
                    o_valid <= 1'b1;
                end else begin
                    o_overrun <= 1'b1;
                end
            end else if (i_read) begin
                o_valid <= 1'b0;
            end
        end
    end

    assign o_busy = (state_q != IDLE);

endmodule
